// File: rtl/mips_pkg.sv
// Shared types and width constants for the MIPS pipeline memory arbiter.
package mips_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_DATA,
    ARB_FETCH
  } arb_state_t;

  typedef enum logic {
    GRANT_DATA,
    GRANT_FETCH
  } grant_t;

endpackage

// File: rtl/arb_watchdog.sv
// Ack-wait watchdog for the unified memory arbiter.
// Counts cycles spent waiting on mem_ack; 'expired' flags the wait cycle in
// which the count would reach TIMEOUT_CYC, so the owner aborts on that edge.
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  // Wait counter: cleared while idle, advances on every un-acked busy cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Expiry when this wait cycle brings the count up to the limit.
  always_comb begin
    expired = count && (cnt == CNT_W'(TIMEOUT_CYC - 1));
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Unified I/D memory arbiter for the 5-stage MIPS pipeline.
// Shares one req/ack memory port between instruction fetch and load/store,
// alternating on collisions, and holds the whole pipeline while busy.
// Optional build macro: ARB_WATCHDOG_EN adds an ack-wait timeout.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W      = mips_pkg::ADDR_W,
  parameter int unsigned DATA_W      = mips_pkg::DATA_W,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              timeout_err
);

  import mips_pkg::*;

  if (TIMEOUT_CYC < 1) begin : g_timeout_range
    $error("TIMEOUT_CYC must be at least 1");
  end

  arb_state_t        state, state_n;
  grant_t            last_grant, last_grant_n;
  logic              mem_we_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n;
  logic [DATA_W-1:0] if_rdata_n, dm_rdata_n;
  logic              if_valid_n, dm_done_n, timeout_n;
  logic              data_pend, fetch_pend, pick_data;
  logic              wd_expired;

  // A request whose completion pulse is showing this cycle is already served;
  // masking it keeps the still-held request from being granted a second time.
  assign data_pend  = (dm_rd | dm_wr) & ~dm_done;
  assign fetch_pend = if_req & ~if_valid;
  assign pick_data  = data_pend & (~fetch_pend | (last_grant == GRANT_FETCH));

  assign mem_req = (state != ARB_IDLE);
  assign stall   = ((dm_rd | dm_wr) & ~dm_done) | (if_req & ~if_valid);

`ifdef ARB_WATCHDOG_EN
  arb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (state == ARB_IDLE),
    .count  (mem_req & ~mem_ack),
    .expired(wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // State, grant history, latched memory fields and registered completions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ARB_IDLE;
      last_grant  <= GRANT_FETCH;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
      if_valid    <= 1'b0;
      dm_done     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      last_grant  <= last_grant_n;
      mem_we      <= mem_we_n;
      mem_addr    <= mem_addr_n;
      mem_wdata   <= mem_wdata_n;
      if_rdata    <= if_rdata_n;
      dm_rdata    <= dm_rdata_n;
      if_valid    <= if_valid_n;
      dm_done     <= dm_done_n;
      timeout_err <= timeout_n;
    end
  end

  // Grant arbitration, ack handling and watchdog abort.
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    mem_we_n     = mem_we;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    if_rdata_n   = if_rdata;
    dm_rdata_n   = dm_rdata;
    if_valid_n   = 1'b0;
    dm_done_n    = 1'b0;
    timeout_n    = 1'b0;

    case (state)
      ARB_IDLE: begin
        if (pick_data) begin
          state_n     = ARB_DATA;
          mem_we_n    = dm_wr;
          mem_addr_n  = dm_addr;
          mem_wdata_n = dm_wdata;
        end else if (fetch_pend) begin
          state_n     = ARB_FETCH;
          mem_we_n    = 1'b0;
          mem_addr_n  = if_addr;
          mem_wdata_n = '0;
        end
      end
      ARB_DATA: begin
        if (mem_ack) begin
          state_n      = ARB_IDLE;
          last_grant_n = GRANT_DATA;
          dm_done_n    = 1'b1;
          if (!mem_we) begin
            dm_rdata_n = mem_rdata;
          end
        end else if (wd_expired) begin
          state_n      = ARB_IDLE;
          last_grant_n = GRANT_DATA;
          dm_done_n    = 1'b1;
          dm_rdata_n   = '0;
          timeout_n    = 1'b1;
        end
      end
      ARB_FETCH: begin
        if (mem_ack) begin
          state_n      = ARB_IDLE;
          last_grant_n = GRANT_FETCH;
          if_valid_n   = 1'b1;
          if_rdata_n   = mem_rdata;
        end else if (wd_expired) begin
          state_n      = ARB_IDLE;
          last_grant_n = GRANT_FETCH;
          if_valid_n   = 1'b1;
          if_rdata_n   = '0;
          timeout_n    = 1'b1;
        end
      end
      default: begin
        state_n = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Sequences a single-ported unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage MIPS pipeline. It runs a grant state machine over a variable-latency req/ack memory port, returns read data to each requester and drives a pipeline-wide stall so PC, IF/ID, ID/EX, EX/MEM and MEM/WB hold while any access is outstanding.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 255, ack wait limit in cycles (used only with watchdog compiled in)

- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction, valid with if_valid
- if_valid  out  1  one-cycle completion pulse for fetch
- dm_rd  in  1  load request, held until dm_done
- dm_wr  in  1  store request, held until dm_done
- dm_addr  in  ADDR_W  data address (MEM_ALUResult)
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, valid with dm_done
- dm_done  out  1  one-cycle completion pulse for load/store
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion from memory
- stall  out  1  pipeline hold
- timeout_err  out  1  one-cycle pulse on watchdog expiry

## Operation
- States: ARB_IDLE, ARB_DATA, ARB_FETCH.
- ARB_IDLE arbitration (sampled at clock edge):
  - data request (dm_rd|dm_wr) and fetch request both present: grant goes opposite to last_grant (1-bit register, reset = FETCH, so data wins first).
  - only one present: grant it.
  - none: stay.
- Grant latches mem_addr/mem_we/mem_wdata from the winner; mem_req = 1 in the granted state. dm_wr and dm_rd both high: treated as write.
- ARB_DATA/ARB_FETCH: hold mem_req and latched fields until mem_ack. On mem_ack: capture mem_rdata into dm_rdata or if_rdata, pulse dm_done or if_valid the next cycle, update last_grant, return to ARB_IDLE.
- dm_rdata on a store: unchanged from previous value.
- stall = (dm_rd|dm_wr) & ~dm_done | if_req & ~if_valid; combinational from inputs and registered pulses.
- Requesters must hold request and fields stable until their completion pulse; the arbiter does not re-sample them after grant.
- mem_ack in ARB_IDLE: ignored.
- Reset: state ARB_IDLE, last_grant FETCH, all outputs 0 including if_rdata/dm_rdata; asserting reset mid-transaction drops mem_req at once and abandons the access; memory must tolerate a withdrawn request.

## Timing
- Grant to mem_req: 1 cycle (request seen in ARB_IDLE at edge N, mem_req high from N+1).
- mem_ack earliest 1 cycle after mem_req rises; completion pulse 1 cycle after mem_ack.
- Minimum access: 3 cycles request-to-pulse; back-to-back accesses separated by one ARB_IDLE cycle.
- Completion pulses and timeout_err are registered, high exactly one cycle.

## Configuration
- ARB_WATCHDOG_EN defined: counter starts at 0 on grant and increments each cycle without mem_ack; when it reaches TIMEOUT_CYC, mem_req drops, timeout_err pulses, the owning requester gets its completion pulse with rdata = 0, state returns to ARB_IDLE.
- Not defined: arbiter waits indefinitely; timeout_err tied 0; no counter logic.

## Structure
- Shared package mips_pkg: arb_state_t enum (ARB_IDLE, ARB_DATA, ARB_FETCH), grant_t (GRANT_DATA, GRANT_FETCH), ADDR_W/DATA_W constants.
- One sub-module: arb_watchdog (counter, clear, expiry flag), instantiated only under ARB_WATCHDOG_EN.

## Test plan
- Fetch only: if_req, if_addr=0x0000_0004, mem_ack 2 cycles after mem_req with 0x2008_0005 -> if_valid one cycle, if_rdata=0x2008_0005, stall low after pulse.
- Simultaneous dm_rd (addr 0x100) and if_req after reset -> data granted first, dm_done then fetch grant; stall high throughout.
- Two consecutive collisions -> grants alternate DATA, FETCH, DATA, FETCH.
- Store dm_wr, dm_wdata=0xCAFE_F00D, addr 0x40 -> mem_we=1, mem_wdata/addr match, dm_done pulse, dm_rdata unchanged.
- reset low while mem_req high in ARB_DATA -> mem_req 0 same cycle, no dm_done, all outputs 0; after release, clean fetch completes.
- With ARB_WATCHDOG_EN, TIMEOUT_CYC=4, no mem_ack -> timeout_err and dm_done pulse after 4 wait cycles, dm_rdata=0, state ARB_IDLE.
